snitch_shared_acc_mux: RTL

SNITCH_SHARED_ACC_MUX -- requirements
Module: snitch_shared_acc_mux

---
 rtl/snitch_shared_acc_mux_pkg.sv | 14 +
 rtl/snitch_shared_acc_mux_rr_arb.sv | 78 +++++++
 rtl/snitch_shared_acc_mux.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/snitch_shared_acc_mux_pkg.sv
// Shared constants and helpers for the shared-accelerator request mux.
// Payload structs depend on module parameters, so they are declared in the module that sizes them.
package snitch_shared_acc_mux_pkg;

  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned InstrWidth = 32;
  // Wide enough for the largest legal MaxOutstanding (15).
  localparam int unsigned CntWidth   = 4;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snitch_shared_acc_mux_rr_arb.sv
// Round-robin arbiter with lock-in: a grant that is offered but not taken
// stays on the same input until the downstream accepts it.
module snitch_shared_acc_mux_rr_arb #(
  parameter int unsigned NumIn    = 2,
  parameter int unsigned IdxWidth = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumIn-1:0]    req_i,
  input  logic                gnt_i,
  output logic [NumIn-1:0]    gnt_o,
  output logic                req_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic                lock_q, lock_d;
  logic [IdxWidth-1:0] sel_idx;
  logic                sel_found;
  int unsigned         cand;

  // Search starts at ptr_q, which holds the index after the last accepted grant.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NumIn; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NumIn) cand = cand - NumIn;
      if (!sel_found && req_i[cand[IdxWidth-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IdxWidth-1:0];
      end
    end
  end

  always_comb begin
    if (lock_q && req_i[lock_idx_q]) begin
      req_o = 1'b1;
      idx_o = lock_idx_q;
    end else begin
      req_o = sel_found;
      idx_o = sel_idx;
    end
    for (int i = 0; i < NumIn; i++) begin
      gnt_o[i] = req_o && (idx_o == IdxWidth'(i));
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (req_o && gnt_i) begin
      ptr_d  = (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + 1'b1;
      lock_d = 1'b0;
    end else if (req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = idx_o;
    end else begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/snitch_shared_acc_mux.sv
// Multiplexes several core accelerator ports onto one shared unit: registered
// round-robin request path, combinational id-routed response path, per-port credit counters.
module snitch_shared_acc_mux
  import snitch_shared_acc_mux_pkg::*;
#(
  parameter int unsigned NrPorts        = 2,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [AddrWidth-1:0]  slv_qaddr_i      [NrPorts],
  input  logic [IdWidth-1:0]    slv_qid_i        [NrPorts],
  input  logic [InstrWidth-1:0] slv_qdata_op_i   [NrPorts],
  input  logic [DataWidth-1:0]  slv_qdata_arga_i [NrPorts],
  input  logic [DataWidth-1:0]  slv_qdata_argb_i [NrPorts],
  input  logic [DataWidth-1:0]  slv_qdata_argc_i [NrPorts],
  input  logic [NrPorts-1:0]    slv_qvalid_i,
  output logic [NrPorts-1:0]    slv_qready_o,
  output logic [DataWidth-1:0]  slv_pdata_o      [NrPorts],
  output logic [IdWidth-1:0]    slv_pid_o        [NrPorts],
  output logic [NrPorts-1:0]    slv_perror_o,
  output logic [NrPorts-1:0]    slv_pvalid_o,
  input  logic [NrPorts-1:0]    slv_pready_i,
  output logic [AddrWidth-1:0]  mst_qaddr_o,
  output logic [IdWidth+idx_width(NrPorts)-1:0] mst_qid_o,
  output logic [InstrWidth-1:0] mst_qdata_op_o,
  output logic [DataWidth-1:0]  mst_qdata_arga_o,
  output logic [DataWidth-1:0]  mst_qdata_argb_o,
  output logic [DataWidth-1:0]  mst_qdata_argc_o,
  output logic                  mst_qvalid_o,
  input  logic                  mst_qready_i,
  input  logic [DataWidth-1:0]  mst_pdata_i,
  input  logic [IdWidth+idx_width(NrPorts)-1:0] mst_pid_i,
  input  logic                  mst_perror_i,
  input  logic                  mst_pvalid_i,
  output logic                  mst_pready_o
);

  localparam int unsigned PortIdxWidth = idx_width(NrPorts);
  localparam int unsigned MstIdWidth   = IdWidth + PortIdxWidth;

  typedef struct packed {
    logic [AddrWidth-1:0]  addr;
    logic [MstIdWidth-1:0] id;
    logic [InstrWidth-1:0] op;
    logic [DataWidth-1:0]  arga;
    logic [DataWidth-1:0]  argb;
    logic [DataWidth-1:0]  argc;
  } mst_req_t;

  logic [NrPorts-1:0]      eligible;
  logic [NrPorts-1:0]      gnt;
  logic [NrPorts-1:0]      incr;
  logic [NrPorts-1:0]      decr;
  logic                    arb_valid;
  logic [PortIdxWidth-1:0] arb_idx;
  logic                    load;
  logic                    valid_q, valid_d;
  mst_req_t                req_q, req_d;
  logic [CntWidth-1:0]     cnt_q [NrPorts];
  logic [CntWidth-1:0]     cnt_d [NrPorts];
  logic [PortIdxWidth-1:0] rsp_port;

  assign load = !valid_q || mst_qready_i;

  snitch_shared_acc_mux_rr_arb #(
    .NumIn    (NrPorts),
    .IdxWidth (PortIdxWidth)
  ) i_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (eligible),
    .gnt_i  (load),
    .gnt_o  (gnt),
    .req_o  (arb_valid),
    .idx_o  (arb_idx)
  );

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (load) begin
      valid_d = arb_valid;
      if (arb_valid) begin
        req_d.addr = slv_qaddr_i[arb_idx];
        req_d.id   = {arb_idx, slv_qid_i[arb_idx]};
        req_d.op   = slv_qdata_op_i[arb_idx];
        req_d.arga = slv_qdata_arga_i[arb_idx];
        req_d.argb = slv_qdata_argb_i[arb_idx];
        req_d.argc = slv_qdata_argc_i[arb_idx];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign mst_qvalid_o     = valid_q;
  assign mst_qaddr_o      = req_q.addr;
  assign mst_qid_o        = req_q.id;
  assign mst_qdata_op_o   = req_q.op;
  assign mst_qdata_arga_o = req_q.arga;
  assign mst_qdata_argb_o = req_q.argb;
  assign mst_qdata_argc_o = req_q.argc;

  // Port indices beyond NrPorts match no gi below, so such responses are dropped.
  assign rsp_port = mst_pid_i[MstIdWidth-1:IdWidth];

  always_comb begin
    mst_pready_o = 1'b1;
    for (int p = 0; p < NrPorts; p++) begin
      if (rsp_port == PortIdxWidth'(p)) mst_pready_o = slv_pready_i[p];
    end
  end

  for (genvar gi = 0; gi < NrPorts; gi++) begin : gen_port
    assign eligible[gi]     = slv_qvalid_i[gi] && (cnt_q[gi] < CntWidth'(MaxOutstanding));
    // Gated by rst_ni so no core sees a handshake while the mux is held in reset.
    assign slv_qready_o[gi] = gnt[gi] && load && rst_ni;
    assign slv_pvalid_o[gi] = mst_pvalid_i && (rsp_port == PortIdxWidth'(gi));
    assign slv_pdata_o[gi]  = mst_pdata_i;
    assign slv_pid_o[gi]    = mst_pid_i[IdWidth-1:0];
    assign slv_perror_o[gi] = mst_perror_i;

    assign incr[gi] = slv_qvalid_i[gi] && slv_qready_o[gi];
    assign decr[gi] = slv_pvalid_o[gi] && slv_pready_i[gi];

    always_comb begin
      cnt_d[gi] = cnt_q[gi];
      if (incr[gi] && !decr[gi] && (cnt_q[gi] < CntWidth'(MaxOutstanding))) begin
        cnt_d[gi] = cnt_q[gi] + 1'b1;
      end else if (decr[gi] && !incr[gi] && (cnt_q[gi] != '0)) begin
        cnt_d[gi] = cnt_q[gi] - 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q[gi] <= '0;
      end else begin
        cnt_q[gi] <= cnt_d[gi];
      end
    end
  end

endmodule
